// File: rtl/cpu_pkg.sv
// Shared constants and the transmitter state type for the serial output stage.
package cpu_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/out_uart_tx_byte_fifo.sv
// Small synchronous FIFO with registered full/empty flags; writes while full are ignored.
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_nx;
    logic             do_push;
    logic             do_pop;

    // Both flags are judged on their pre-edge values, so a pop cannot make room
    // for a write on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_nx = count;
        case ({do_push, do_pop})
            2'b10:   count_nx = count + 1'b1;
            2'b01:   count_nx = count - 1'b1;
            default: count_nx = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nx;
            full  <= (count_nx == (AW+1)'(DEPTH));
            empty <= (count_nx == '0);
        end
    end

endmodule

// File: rtl/out_uart_tx.sv
// Buffered UART transmitter fed by the cpu accumulator output.
// Define OUT_UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module out_uart_tx
    import cpu_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_wr,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_busy,
    output logic              o_overflow,
    output logic              o_tx
);

    localparam int            BW        = $clog2(CLK_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

    tx_state_t         state;
    logic [BW-1:0]     baud;
    logic [2:0]        bit_cnt;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] rd_data;
    logic              last_tick;
    logic              pop;
    logic              shift_en;
`ifdef OUT_UART_PARITY_EN
    logic              par_bit;
`endif

    assign last_tick = (baud == BAUD_LAST);
    assign pop       = !o_empty && ((state == IDLE) || ((state == STOP) && last_tick));
    assign shift_en  = (state == DATA) && last_tick;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .clr   (clr),
        .push  (i_wr),
        .pop   (pop),
        .wdata (i_data),
        .rdata (rd_data),
        .full  (o_full),
        .empty (o_empty)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            o_overflow <= 1'b0;
        end else if (i_wr && o_full) begin
            o_overflow <= 1'b1;
        end
    end

    // Parity is taken from the byte as loaded, since the shift register is consumed bit by bit.
    always_ff @(posedge clk) begin
        if (pop) begin
            shift <= rd_data;
        end else if (shift_en) begin
            shift <= {1'b0, shift[DATA_W-1:1]};
        end
`ifdef OUT_UART_PARITY_EN
        if (pop) begin
            par_bit <= ^rd_data;
        end
`endif
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            o_tx    <= 1'b1;
            o_busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    baud    <= '0;
                    bit_cnt <= '0;
                    o_tx    <= 1'b1;
                    if (pop) begin
                        state  <= START;
                        o_tx   <= 1'b0;
                        o_busy <= 1'b1;
                    end
                end
                START: begin
                    if (last_tick) begin
                        baud  <= '0;
                        state <= DATA;
                        o_tx  <= shift[0];
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (last_tick) begin
                        baud <= '0;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
`ifdef OUT_UART_PARITY_EN
                            state   <= PARITY;
                            o_tx    <= par_bit;
`else
                            state   <= STOP;
                            o_tx    <= 1'b1;
`endif
                        end else begin
                            // The next bit is the one about to shift into position 0.
                            bit_cnt <= bit_cnt + 1'b1;
                            o_tx    <= shift[1];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
`ifdef OUT_UART_PARITY_EN
                PARITY: begin
                    if (last_tick) begin
                        baud  <= '0;
                        state <= STOP;
                        o_tx  <= 1'b1;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (last_tick) begin
                        baud <= '0;
                        if (pop) begin
                            state <= START;
                            o_tx  <= 1'b0;
                        end else begin
                            state  <= IDLE;
                            o_tx   <= 1'b1;
                            o_busy <= 1'b0;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    baud   <= '0;
                    o_tx   <= 1'b1;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_out_uart_tx.sv
// Randomised scoreboard bench for out_uart_tx: a queue-level model predicts accepted bytes and
// flags, and a serial receiver decodes the line and compares each frame against the queue.
module tb_out_uart_tx;
    import cpu_pkg::*;

    localparam int CD    = 4;
    localparam int DEPTH = 4;
`ifdef OUT_UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CD;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [7:0] i_data = 8'h00;
    logic       i_wr = 1'b0;
    logic       o_full;
    logic       o_empty;
    logic       o_busy;
    logic       o_overflow;
    logic       o_tx;

    always #5 clk = ~clk;

    out_uart_tx #(
        .CLK_DIV    (CD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .i_data     (i_data),
        .i_wr       (i_wr),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_busy     (o_busy),
        .o_overflow (o_overflow),
        .o_tx       (o_tx)
    );

    int         compared   = 0;
    int         mismatched = 0;
    logic [7:0] fifo_m[$];
    logic [7:0] exp_q[$];
    int         rem = 0;
    logic       ovf_m = 1'b0;
    bit         full_pre;
    bit         pop_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: a frame lasts FRAME cycles; the next byte leaves the queue when the line
    // is idle or on the final cycle of a frame. Fullness is judged before the edge.
    initial forever begin
        @(posedge clk);
        if (clr) begin
            fifo_m.delete();
            exp_q.delete();
            rem   = 0;
            ovf_m = 1'b0;
        end else begin
            full_pre = (fifo_m.size() == DEPTH);
            pop_m    = (fifo_m.size() > 0) && (rem <= 1);
            if (pop_m) begin
                exp_q.push_back(fifo_m.pop_front());
                rem = FRAME;
            end else if (rem > 0) begin
                rem--;
            end
            if (i_wr) begin
                if (full_pre) ovf_m = 1'b1;
                else          fifo_m.push_back(i_data);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        #1;
        if (clr) begin
            check("rst_tx", o_tx, 1);
            check("rst_busy", o_busy, 0);
            check("rst_empty", o_empty, 1);
            check("rst_full", o_full, 0);
            check("rst_overflow", o_overflow, 0);
        end else begin
            check("full", o_full, fifo_m.size() == DEPTH);
            check("empty", o_empty, fifo_m.size() == 0);
            check("busy", o_busy, rem > 0);
            check("overflow", o_overflow, ovf_m);
            if (rem == 0) check("idle_line", o_tx, 1);
        end
    end

    logic [NBITS-1:0] bits;
    bit               shape_ok;
    bit               aborted;

    // Line receiver: every sample of a bit-time must agree; start 0, stop 1, data LSB first.
    initial forever begin
        @(negedge clk);
        if (!clr && o_tx === 1'b0) begin
            shape_ok = 1'b1;
            aborted  = 1'b0;
            bits     = '0;
            for (int b = 0; b < NBITS && !aborted; b++) begin
                for (int s = 0; s < CD && !aborted; s++) begin
                    if (b != 0 || s != 0) @(negedge clk);
                    if (clr) aborted = 1'b1;
                    else if (s == 0) bits[b] = o_tx;
                    else if (o_tx !== bits[b]) shape_ok = 1'b0;
                end
            end
            if (!aborted) begin
                check("bit_hold", shape_ok, 1);
                check("start_bit", bits[0], 0);
                check("stop_bit", bits[NBITS-1], 1);
`ifdef OUT_UART_PARITY_EN
                check("parity_bit", bits[9], ^bits[8:1]);
`endif
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                end else begin
                    check("frame_byte", bits[8:1], exp_q.pop_front());
                end
            end
        end
    end

    task automatic push(input logic [7:0] d);
        @(negedge clk);
        #2;
        i_wr   = 1'b1;
        i_data = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
            i_wr = 1'b0;
        end
    endtask

    task automatic drive_random(input int n, input int one_in);
        repeat (n) begin
            @(negedge clk);
            #2;
            i_wr   = ($urandom_range(0, one_in - 1) == 0);
            i_data = 8'($urandom);
        end
    endtask

    task automatic wait_drain(input int max_cycles);
        int c;
        c = 0;
        while ((rem != 0 || fifo_m.size() != 0 || exp_q.size() != 0) && c < max_cycles) begin
            @(negedge clk);
            c++;
        end
        check("drain_in_time", c < max_cycles, 1);
        idle(2);
    endtask

    task automatic pulse_reset(input int n);
        @(negedge clk);
        #2;
        clr = 1'b1;
        repeat (n) @(negedge clk);
        #2;
        clr = 1'b0;
    endtask

    initial begin
        clr = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        clr = 1'b0;

        push(8'hA5);
        idle(1);
        wait_drain(200);

        for (int k = 1; k <= 6; k++) push(8'(k));
        idle(1);
        check("overflow_after_burst", o_overflow, 1);
        check("full_after_burst", o_full, 1);
        wait_drain(400);
        pulse_reset(2);

        push(8'h07);
        push(8'h03);
        idle(1);
        wait_drain(300);

        push(8'h5A);
        push(8'hC3);
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        idle(14);
        clr = 1'b1;
        #1;
        check("midframe_tx", o_tx, 1);
        check("midframe_busy", o_busy, 0);
        check("midframe_empty", o_empty, 1);
        check("midframe_overflow", o_overflow, 0);
        repeat (2) @(negedge clk);
        #2;
        clr = 1'b0;
        idle(60);

        for (int k = 0; k < 6; k++) push(8'(8'h80 + k));
        drive_random(50, 1);
        idle(1);
        wait_drain(600);
        pulse_reset(2);

        drive_random(300, 12);
        drive_random(300, 3);
        idle(1);
        wait_drain(1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
